// File: rtl/ram_block_alu_pkg.sv
// Shared op codes and FSM encoding for the RAM block-operation sequencer.
package ram_block_alu_pkg;

  localparam int OP_WIDTH = 3;

  localparam logic [OP_WIDTH-1:0] OP_ADD  = 3'd0;
  localparam logic [OP_WIDTH-1:0] OP_SUB  = 3'd1;
  localparam logic [OP_WIDTH-1:0] OP_AND  = 3'd2;
  localparam logic [OP_WIDTH-1:0] OP_OR   = 3'd3;
  localparam logic [OP_WIDTH-1:0] OP_XOR  = 3'd4;
  localparam logic [OP_WIDTH-1:0] OP_NOTA = 3'd5;
  localparam logic [OP_WIDTH-1:0] OP_MOVA = 3'd6;
  localparam logic [OP_WIDTH-1:0] OP_CMP  = 3'd7;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StExec,
    StWrite,
    StDone
  } state_t;

endpackage

// File: rtl/ram_block_alu_core.sv
// Combinational element ALU; cout is carry-out for ADD and borrow-out for SUB/CMP.
module ram_block_alu_core
  import ram_block_alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0]    a,
  input  logic [WIDTH-1:0]    b,
  input  logic [OP_WIDTH-1:0] op,
  input  logic                cin,
  output logic [WIDTH-1:0]    result,
  output logic                cout
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] diff;

  assign sum  = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
  assign diff = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, cin};

  always_comb begin
    result = '0;
    cout   = 1'b0;
    case (op)
      OP_ADD:          {cout, result} = sum;
      OP_SUB, OP_CMP:  {cout, result} = diff;
      OP_AND:          result = a & b;
      OP_OR:           result = a | b;
      OP_XOR:          result = a ^ b;
      OP_NOTA:         result = ~a;
      OP_MOVA:         result = a;
      default:         result = '0;
    endcase
  end

endmodule

// File: rtl/ram_block_alu.sv
// Sequences one ALU op element-wise over a RAM block (fetch/exec/write per word).
// Optional RAM_BLOCK_ALU_FLAGS_EN chains carry/borrow across elements and tracks zero.
module ram_block_alu
  import ram_block_alu_pkg::*;
#(
  parameter int AWIDTH = 8,
  parameter int WIDTH  = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [OP_WIDTH-1:0] op,
  input  logic [AWIDTH-1:0]   src_a,
  input  logic [AWIDTH-1:0]   src_b,
  input  logic [AWIDTH-1:0]   dst,
  input  logic [AWIDTH-1:0]   len,
  output logic                busy,
  output logic                done,
  output logic [AWIDTH-1:0]   port_a_address,
  input  logic [WIDTH-1:0]    port_a_out,
  output logic [AWIDTH-1:0]   port_b_address,
  input  logic [WIDTH-1:0]    port_b_out,
  output logic [AWIDTH-1:0]   port_c_address,
  output logic [WIDTH-1:0]    port_c_data,
  output logic                port_c_we,
  output logic                carry,
  output logic                zero
);

  state_t              state_q, state_d;
  logic [OP_WIDTH-1:0] op_q;
  logic [AWIDTH-1:0]   src_a_q, src_b_q, dst_q, len_q;
  logic [AWIDTH-1:0]   i_q, i_d;
  logic                accept;
  logic                last;
  logic [AWIDTH-1:0]   a_base, b_base;
  logic [WIDTH-1:0]    res;
  logic                cin, cout;

  assign last   = (i_q == (len_q - AWIDTH'(1)));
  assign a_base = accept ? src_a : src_a_q;
  assign b_base = accept ? src_b : src_b_q;
  assign busy   = (state_q == StFetch) || (state_q == StExec) || (state_q == StWrite);
  assign done   = (state_q == StDone);

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    accept  = 1'b0;
    case (state_q)
      StIdle: begin
        if (start) begin
          accept  = 1'b1;
          i_d     = '0;
          state_d = (len == '0) ? StDone : StFetch;
        end
      end
      StFetch: state_d = StExec;
      StExec:  state_d = StWrite;
      StWrite: begin
        if (last) begin
          state_d = StDone;
        end else begin
          i_d     = i_q + AWIDTH'(1);
          state_d = StFetch;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= StIdle;
      i_q            <= '0;
      op_q           <= '0;
      src_a_q        <= '0;
      src_b_q        <= '0;
      dst_q          <= '0;
      len_q          <= '0;
      port_a_address <= '0;
      port_b_address <= '0;
      port_c_address <= '0;
      port_c_data    <= '0;
      port_c_we      <= 1'b0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      if (accept) begin
        op_q    <= op;
        src_a_q <= src_a;
        src_b_q <= src_b;
        dst_q   <= dst;
        len_q   <= len;
      end
      // Addresses are presented for the whole FETCH cycle; RAM data lands in EXEC.
      if (state_d == StFetch) begin
        port_a_address <= a_base + i_d;
        port_b_address <= b_base + i_d;
      end
      if (state_q == StExec) begin
        port_c_address <= dst_q + i_q;
        port_c_data    <= res;
      end
      port_c_we <= (state_q == StExec) && (op_q != OP_CMP);
    end
  end

  ram_block_alu_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .a      (port_a_out),
    .b      (port_b_out),
    .op     (op_q),
    .cin    (cin),
    .result (res),
    .cout   (cout)
  );

`ifdef RAM_BLOCK_ALU_FLAGS_EN
  logic carry_q, zero_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
    end else if (accept) begin
      carry_q <= 1'b0;
      zero_q  <= 1'b1;
    end else if (state_q == StExec) begin
      if ((op_q == OP_ADD) || (op_q == OP_SUB) || (op_q == OP_CMP)) begin
        carry_q <= cout;
      end
      zero_q <= zero_q & (res == '0);
    end
  end

  assign cin   = carry_q;
  assign carry = carry_q;
  assign zero  = zero_q;
`else
  logic unused_cout;

  assign unused_cout = cout;
  assign cin         = 1'b0;
  assign carry       = 1'b0;
  assign zero        = 1'b0;
`endif

endmodule

// File: tb/tb_ram_block_alu.sv
// Scoreboarded bench for ram_block_alu with a registered-read three-port RAM model.
module tb_ram_block_alu;

  localparam logic [2:0] ADD = 3'd0, SUB = 3'd1, AND_ = 3'd2, OR_ = 3'd3;
  localparam logic [2:0] XOR_ = 3'd4, NOTA = 3'd5, MOVA = 3'd6, CMP = 3'd7;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [2:0] op = '0;
  logic [7:0] src_a = '0, src_b = '0, dst = '0, len = '0;
  logic       busy, done, port_c_we, carry, zero;
  logic [7:0] port_a_address, port_b_address, port_c_address, port_c_data;
  logic [7:0] port_a_out = '0, port_b_out = '0;

  logic [7:0] mem [256] = '{default: 8'h00};
  logic       ld_en = 1'b0;
  logic [7:0] ld_addr = '0, ld_data = '0;

  int checks = 0;
  int failures = 0;
  int done_count = 0;
  logic [15:0] exp_q[$];

  always #5 clk = ~clk;

  ram_block_alu #(
    .AWIDTH(8),
    .WIDTH (8)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .op             (op),
    .src_a          (src_a),
    .src_b          (src_b),
    .dst            (dst),
    .len            (len),
    .busy           (busy),
    .done           (done),
    .port_a_address (port_a_address),
    .port_a_out     (port_a_out),
    .port_b_address (port_b_address),
    .port_b_out     (port_b_out),
    .port_c_address (port_c_address),
    .port_c_data    (port_c_data),
    .port_c_we      (port_c_we),
    .carry          (carry),
    .zero           (zero)
  );

  always @(posedge clk) begin
    port_a_out <= mem[port_a_address];
    port_b_out <= mem[port_b_address];
    if (port_c_we) mem[port_c_address] <= port_c_data;
    if (ld_en) mem[ld_addr] <= ld_data;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every presented write must match the next scoreboard entry.
  always @(negedge clk) begin
    logic [15:0] e;
    if (done) done_count++;
    if (port_c_we) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write: got addr %0h data %0h expected none",
                 port_c_address, port_c_data);
      end else begin
        e = exp_q.pop_front();
        chk("write", {16'h0, port_c_address, port_c_data}, {16'h0, e});
      end
    end
  end

  task automatic poke(input logic [7:0] a, input logic [7:0] d);
    ld_en = 1'b1;
    ld_addr = a;
    ld_data = d;
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  task automatic push(input logic [7:0] a, input logic [7:0] d);
    exp_q.push_back({a, d});
  endtask

  // Issue a request and time done; pulse_at>0 injects a second start while busy.
  task automatic run_op(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] d, input logic [7:0] l, input int pulse_at);
    int n, bc;
    bit got;
    op = o; src_a = a; src_b = b; dst = d; len = l; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    n = 0; bc = 0; got = 0;
    while (!got && n < 200) begin
      @(negedge clk);
      n++;
      if (busy) bc++;
      if (done) got = 1;
      if (n == pulse_at) begin
        start = 1'b1; op = ADD; src_a = 8'h10; src_b = 8'h20; dst = 8'hA0; len = 8'd1;
      end else begin
        start = 1'b0;
      end
    end
    chk("done_cycle", n, 3 * int'(l) + 1);
    chk("busy_cycles", bc, 3 * int'(l));
    chk("writes_drained", exp_q.size(), 0);
    @(negedge clk);
    chk("done_one_cycle", done, 1'b0);
  endtask

  initial begin
    int dc0, n;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_we", port_c_we, 1'b0);
    chk("rst_a_addr", port_a_address, 8'h00);
    chk("rst_c_addr", port_c_address, 8'h00);
    chk("rst_c_data", port_c_data, 8'h00);
    chk("rst_carry", carry, 1'b0);
    chk("rst_zero", zero, 1'b0);
    rst = 1'b0;

    poke(8'h10, 8'h01); poke(8'h11, 8'h02); poke(8'h12, 8'h03); poke(8'h13, 8'h04);
    poke(8'h20, 8'h10); poke(8'h21, 8'h20); poke(8'h22, 8'h30); poke(8'h23, 8'h40);
    poke(8'h40, 8'hFF); poke(8'h41, 8'h01); poke(8'h50, 8'h01); poke(8'h51, 8'h00);
    poke(8'h70, 8'h05); poke(8'h71, 8'h00); poke(8'h78, 8'h06); poke(8'h79, 8'h00);
    poke(8'hFE, 8'hAA); poke(8'hFF, 8'hBB); poke(8'h00, 8'hCC);

    // Basic 4-element ADD
    push(8'h30, 8'h11); push(8'h31, 8'h22); push(8'h32, 8'h33); push(8'h33, 8'h44);
    run_op(ADD, 8'h10, 8'h20, 8'h30, 8'd4, -1);
    chk("mem_33", mem[8'h33], 8'h44);

    // Multi-word ADD: carry propagates only with flags
    push(8'h60, 8'h00);
`ifdef RAM_BLOCK_ALU_FLAGS_EN
    push(8'h61, 8'h02);
`else
    push(8'h61, 8'h01);
`endif
    run_op(ADD, 8'h40, 8'h50, 8'h60, 8'd2, -1);
    chk("add_carry", carry, 1'b0);
    chk("add_zero", zero, 1'b0);

    // Multi-word SUB with borrow out of the top word
    push(8'h68, 8'hFF);
`ifdef RAM_BLOCK_ALU_FLAGS_EN
    push(8'h69, 8'hFF);
    run_op(SUB, 8'h70, 8'h78, 8'h68, 8'd2, -1);
    chk("sub_borrow", carry, 1'b1);
`else
    push(8'h69, 8'h00);
    run_op(SUB, 8'h70, 8'h78, 8'h68, 8'd2, -1);
    chk("sub_borrow", carry, 1'b0);
`endif

    // CMP of equal blocks never writes
    run_op(CMP, 8'h10, 8'h10, 8'hD0, 8'd3, -1);
`ifdef RAM_BLOCK_ALU_FLAGS_EN
    chk("cmp_zero", zero, 1'b1);
`else
    chk("cmp_zero", zero, 1'b0);
`endif
    chk("cmp_carry", carry, 1'b0);

    // Logic ops, one element each: a=03, b=30
    push(8'h80, 8'h00);
    run_op(AND_, 8'h12, 8'h22, 8'h80, 8'd1, -1);
    push(8'h81, 8'h33);
    run_op(OR_, 8'h12, 8'h22, 8'h81, 8'd1, -1);
    push(8'h82, 8'h33);
    run_op(XOR_, 8'h12, 8'h22, 8'h82, 8'd1, -1);
    push(8'h83, 8'hFC);
    run_op(NOTA, 8'h12, 8'h22, 8'h83, 8'd1, -1);

    // len=0 is a no-op that completes at cycle 1
    run_op(ADD, 8'h10, 8'h20, 8'hE0, 8'd0, -1);

    // Start during busy is dropped
    dc0 = done_count;
    push(8'h90, 8'h01); push(8'h91, 8'h02); push(8'h92, 8'h03); push(8'h93, 8'h04);
    run_op(MOVA, 8'h10, 8'h00, 8'h90, 8'd4, 5);
    repeat (10) @(negedge clk);
    chk("single_done", done_count - dc0, 1);
    chk("ignored_no_write", mem[8'hA0], 8'h00);

    // Address wrap with overlapping MOVA smearing
    push(8'hFF, 8'hAA); push(8'h00, 8'hAA); push(8'h01, 8'hAA);
    run_op(MOVA, 8'hFE, 8'h00, 8'hFF, 8'd3, -1);
    chk("wrap_src_kept", mem[8'hFE], 8'hAA);
    chk("wrap_mem_01", mem[8'h01], 8'hAA);

    // Reset during WRITE of element 1
    push(8'hB0, 8'h11); push(8'hB1, 8'h22);
    op = ADD; src_a = 8'h10; src_b = 8'h20; dst = 8'hB0; len = 8'd4; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(port_c_we && port_c_address == 8'hB1) && n < 50);
    chk("reach_write1", n < 50, 1'b1);
    #1 rst = 1'b1;
    #1;
    chk("rst_mid_we", port_c_we, 1'b0);
    chk("rst_mid_busy", busy, 1'b0);
    chk("rst_mid_done", done, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid_elem0", mem[8'hB0], 8'h11);
    chk("rst_mid_elem1", mem[8'hB1], 8'h00);
    chk("rst_mid_drained", exp_q.size(), 0);
    push(8'hC0, 8'h11);
    run_op(ADD, 8'h10, 8'h20, 8'hC0, 8'd1, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
